// File: rtl/vc32_mem_arbiter.sv
// vc32_mem_arbiter: shares one external-memory bus controller between the CPU
// (port 0) and a secondary master (port 1).
//
// Handshake: a port requests by driving a nonzero rreq and/or wmask. It must
// hold addr/data/req steady until its done pulse. Done pulses are single-cycle,
// come from the bus controller, and are routed only to the granted port. There
// is no backpressure beyond that: the request is the valid, the done the ack.
//
// Flow: IDLE arbitrates and latches a one-hot grant. BUSY forwards the granted
// port to the slave combinationally until any done. DRAIN is one forced-quiet
// cycle, so a request left asserted is never re-forwarded.
module vc32_mem_arbiter #(
  parameter  int RV         = 32,
  parameter  int FIXED_PRIO = 0,
  parameter  int STARVE_MAX = 4,
  localparam int AW         = RV - RV / 16,
  localparam int MW         = RV / 8
) (
  input  logic          clk,
  input  logic          r_reset,
  input  logic          ena,
  input  logic [AW-1:0] m0_raddr,
  input  logic [1:0]    m0_rreq,
  input  logic [AW-1:0] m0_waddr,
  input  logic [MW-1:0] m0_wmask,
  input  logic [RV-1:0] m0_wdata,
  input  logic [AW-1:0] m1_raddr,
  input  logic [1:0]    m1_rreq,
  input  logic [AW-1:0] m1_waddr,
  input  logic [MW-1:0] m1_wmask,
  input  logic [RV-1:0] m1_wdata,
  output logic          m0_rdone,
  output logic          m0_wdone,
  output logic          m1_rdone,
  output logic          m1_wdone,
  output logic [RV-1:0] m_rdata,
  output logic [AW-1:0] s_raddr,
  output logic [1:0]    s_rreq,
  output logic [AW-1:0] s_waddr,
  output logic [MW-1:0] s_wmask,
  output logic [RV-1:0] s_wdata,
  input  logic          s_rdone,
  input  logic          s_wdone,
  input  logic [RV-1:0] s_rdata,
  output logic [1:0]    grant,
  output logic [1:0]    o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Starvation counter must hold STARVE_MAX; keep at least one bit.
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  state_t        r_state, w_state_n;
  logic [1:0]    r_grant, w_grant_n;
  logic          r_last, w_last_n;     // index of the port granted most recently
  logic [SW-1:0] r_starve, w_starve_n;

  logic w_pend0, w_pend1, w_win1, w_busy, w_sel1, w_done;

  assign w_pend0 = (|m0_rreq) | (|m0_wmask);
  assign w_pend1 = (|m1_rreq) | (|m1_wmask);
  assign w_busy  = (r_state == BUSY);
  assign w_sel1  = r_grant[1];
  assign w_done  = s_rdone | s_wdone;

  // Winner selection: sole pender wins; ties go by policy.
  always_comb begin
    w_win1 = 1'b0;
    if (FIXED_PRIO != 0)
      w_win1 = w_pend1 & (~w_pend0 | (r_starve == SW'(STARVE_MAX)));
    else
      w_win1 = w_pend1 & (~w_pend0 | ~r_last);
  end

  // Next-state, next-grant and starvation bookkeeping.
  always_comb begin
    w_state_n  = r_state;
    w_grant_n  = r_grant;
    w_last_n   = r_last;
    w_starve_n = r_starve;
    case (r_state)
      IDLE: begin
        if (!w_pend1)
          w_starve_n = '0;
        if (w_pend0 | w_pend1) begin
          w_state_n = BUSY;
          w_grant_n = w_win1 ? 2'b10 : 2'b01;
          w_last_n  = w_win1;
          if (w_win1)
            w_starve_n = '0;
          else if (w_pend1 && (r_starve != SW'(STARVE_MAX)))
            w_starve_n = r_starve + 1'b1;
        end
      end
      BUSY: begin
        if (w_done)
          w_state_n = DRAIN;
      end
      DRAIN: begin
        w_state_n = IDLE;
        w_grant_n = 2'b00;
      end
      default: begin
        w_state_n = IDLE;
        w_grant_n = 2'b00;
      end
    endcase
  end

  // State registers; ena=0 freezes everything, reset wins in any state.
  always_ff @(posedge clk) begin
    if (r_reset) begin
      r_state  <= IDLE;
      r_grant  <= 2'b00;
      r_last   <= 1'b1;
      r_starve <= '0;
    end else if (ena) begin
      r_state  <= w_state_n;
      r_grant  <= w_grant_n;
      r_last   <= w_last_n;
      r_starve <= w_starve_n;
    end
  end

  // Slave-side mux from the granted port; requests forced quiet outside BUSY.
  always_comb begin
    s_raddr = w_sel1 ? m1_raddr : m0_raddr;
    s_waddr = w_sel1 ? m1_waddr : m0_waddr;
    s_wdata = w_sel1 ? m1_wdata : m0_wdata;
    s_rreq  = '0;
    s_wmask = '0;
    if (w_busy) begin
      s_rreq  = w_sel1 ? m1_rreq  : m0_rreq;
      s_wmask = w_sel1 ? m1_wmask : m0_wmask;
    end
  end

  // Done pulses reach only the granted port and only while BUSY.
  always_comb begin
    m0_rdone = w_busy & r_grant[0] & s_rdone;
    m0_wdone = w_busy & r_grant[0] & s_wdone;
    m1_rdone = w_busy & r_grant[1] & s_rdone;
    m1_wdone = w_busy & r_grant[1] & s_wdone;
  end

  assign m_rdata     = s_rdata;
  assign grant       = r_grant;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vc32_mem_arbiter.sv
// Directed bench for vc32_mem_arbiter: one round-robin instance and one
// fixed-priority instance share all inputs; each task checks the one it targets.
module tb_vc32_mem_arbiter;

  localparam int RV = 32;
  localparam int AW = RV - RV / 16;
  localparam int MW = RV / 8;
  localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_DRAIN = 2'd2;

  int checks = 0;
  int errors = 0;

  // clock / reset
  logic clk = 1'b0;
  logic r_reset = 1'b1;
  logic ena = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] m0_raddr = '0, m0_waddr = '0, m1_raddr = '0, m1_waddr = '0;
  logic [1:0]    m0_rreq = '0, m1_rreq = '0;
  logic [MW-1:0] m0_wmask = '0, m1_wmask = '0;
  logic [RV-1:0] m0_wdata = '0, m1_wdata = '0, s_rdata = '0;
  logic          s_rdone = 1'b0, s_wdone = 1'b0;

  logic          a_m0_rdone, a_m0_wdone, a_m1_rdone, a_m1_wdone;
  logic [RV-1:0] a_m_rdata, a_s_wdata;
  logic [AW-1:0] a_s_raddr, a_s_waddr;
  logic [1:0]    a_s_rreq, a_grant, a_state;
  logic [MW-1:0] a_s_wmask;

  logic          b_m0_rdone, b_m0_wdone, b_m1_rdone, b_m1_wdone;
  logic [RV-1:0] b_m_rdata, b_s_wdata;
  logic [AW-1:0] b_s_raddr, b_s_waddr;
  logic [1:0]    b_s_rreq, b_grant, b_state;
  logic [MW-1:0] b_s_wmask;

  vc32_mem_arbiter #(.RV(RV), .FIXED_PRIO(0), .STARVE_MAX(4)) dut_rr (
    .clk(clk), .r_reset(r_reset), .ena(ena),
    .m0_raddr(m0_raddr), .m0_rreq(m0_rreq), .m0_waddr(m0_waddr),
    .m0_wmask(m0_wmask), .m0_wdata(m0_wdata),
    .m1_raddr(m1_raddr), .m1_rreq(m1_rreq), .m1_waddr(m1_waddr),
    .m1_wmask(m1_wmask), .m1_wdata(m1_wdata),
    .m0_rdone(a_m0_rdone), .m0_wdone(a_m0_wdone),
    .m1_rdone(a_m1_rdone), .m1_wdone(a_m1_wdone),
    .m_rdata(a_m_rdata), .s_raddr(a_s_raddr), .s_rreq(a_s_rreq),
    .s_waddr(a_s_waddr), .s_wmask(a_s_wmask), .s_wdata(a_s_wdata),
    .s_rdone(s_rdone), .s_wdone(s_wdone), .s_rdata(s_rdata),
    .grant(a_grant), .o_dbg_state(a_state)
  );

  vc32_mem_arbiter #(.RV(RV), .FIXED_PRIO(1), .STARVE_MAX(4)) dut_fp (
    .clk(clk), .r_reset(r_reset), .ena(ena),
    .m0_raddr(m0_raddr), .m0_rreq(m0_rreq), .m0_waddr(m0_waddr),
    .m0_wmask(m0_wmask), .m0_wdata(m0_wdata),
    .m1_raddr(m1_raddr), .m1_rreq(m1_rreq), .m1_waddr(m1_waddr),
    .m1_wmask(m1_wmask), .m1_wdata(m1_wdata),
    .m0_rdone(b_m0_rdone), .m0_wdone(b_m0_wdone),
    .m1_rdone(b_m1_rdone), .m1_wdone(b_m1_wdone),
    .m_rdata(b_m_rdata), .s_raddr(b_s_raddr), .s_rreq(b_s_rreq),
    .s_waddr(b_s_waddr), .s_wmask(b_s_wmask), .s_wdata(b_s_wdata),
    .s_rdone(s_rdone), .s_wdone(s_wdone), .s_rdata(s_rdata),
    .grant(b_grant), .o_dbg_state(b_state)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_rreq = '0; m1_rreq = '0; m0_wmask = '0; m1_wmask = '0;
    s_rdone = 1'b0; s_wdone = 1'b0; ena = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    r_reset = 1'b1;
    tick();
    tick();
    r_reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    r_reset = 1'b1;
    tick();
    tick();
    checks++;
    if (a_grant !== 2'b00 || a_s_wmask !== '0 || a_s_rreq !== 2'b00 || a_state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_outputs: grant=%b wmask=%b rreq=%b state=%0d, need 00/0/00/0",
               a_grant, a_s_wmask, a_s_rreq, a_state);
    end
    checks++;
    if ({a_m0_rdone, a_m0_wdone, a_m1_rdone, a_m1_wdone} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_dones: got %b need 0000",
               {a_m0_rdone, a_m0_wdone, a_m1_rdone, a_m1_wdone});
    end
    // Reset asserted mid-BUSY abandons the transfer.
    r_reset = 1'b0;
    m1_rreq = 2'b10;
    m1_raddr = 30'h77;
    tick();
    checks++;
    if (a_grant !== 2'b10 || a_state !== S_BUSY) begin
      errors++;
      $display("FAIL reset_pre_busy: grant=%b state=%0d need 10/1", a_grant, a_state);
    end
    r_reset = 1'b1;
    tick();
    checks++;
    if (a_grant !== 2'b00 || a_state !== S_IDLE || a_s_rreq !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_busy: grant=%b state=%0d rreq=%b need 00/0/00",
               a_grant, a_state, a_s_rreq);
    end
    s_rdone = 1'b1;
    #1;
    checks++;
    if (a_m1_rdone !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: m1_rdone=%b need 0", a_m1_rdone);
    end
    clear_inputs();
    r_reset = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    m0_rreq = 2'b11;
    m0_raddr = 30'h100;
    s_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (a_s_rreq !== 2'b00) begin
      errors++;
      $display("FAIL read_idle_quiet: s_rreq=%b need 00", a_s_rreq);
    end
    tick();
    checks++;
    if (a_grant !== 2'b01 || a_s_rreq !== 2'b11 || a_s_raddr !== 30'h100 || a_state !== S_BUSY) begin
      errors++;
      $display("FAIL read_forward: grant=%b rreq=%b raddr=%h state=%0d need 01/11/100/1",
               a_grant, a_s_rreq, a_s_raddr, a_state);
    end
    s_rdone = 1'b1;
    #1;
    checks++;
    if (a_m0_rdone !== 1'b1 || a_m1_rdone !== 1'b0 || a_m_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_done: m0_rdone=%b m1_rdone=%b rdata=%h need 1/0/deadbeef",
               a_m0_rdone, a_m1_rdone, a_m_rdata);
    end
    tick();
    s_rdone = 1'b0;
    checks++;
    if (a_state !== S_DRAIN || a_s_rreq !== 2'b00 || a_grant !== 2'b01) begin
      errors++;
      $display("FAIL read_drain: state=%0d rreq=%b grant=%b need 2/00/01",
               a_state, a_s_rreq, a_grant);
    end
    m0_rreq = 2'b00;
    tick();
    checks++;
    if (a_state !== S_IDLE || a_grant !== 2'b00) begin
      errors++;
      $display("FAIL read_idle: state=%0d grant=%b need 0/00", a_state, a_grant);
    end
  endtask

  // Both ports pend continuously; each transfer is IDLE, BUSY(done), DRAIN.
  task automatic test_rr_tie();
    logic [1:0] exp_g [4];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    do_reset();
    m0_rreq = 2'b01; m0_raddr = 30'h0AA;
    m1_rreq = 2'b10; m1_raddr = 30'h0BB;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (a_grant !== exp_g[i] || a_s_raddr !== (exp_g[i][1] ? 30'h0BB : 30'h0AA)) begin
        errors++;
        $display("FAIL rr_grant[%0d]: grant=%b raddr=%h need %b", i, a_grant, a_s_raddr, exp_g[i]);
      end
      s_rdone = 1'b1;
      #1;
      checks++;
      if ({a_m1_rdone, a_m0_rdone} !== exp_g[i]) begin
        errors++;
        $display("FAIL rr_done_route[%0d]: m1/m0 rdone=%b need %b",
                 i, {a_m1_rdone, a_m0_rdone}, exp_g[i]);
      end
      tick();
      s_rdone = 1'b0;
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_fixed_prio();
    logic [1:0] exp_g;
    do_reset();
    m0_rreq = 2'b01; m1_rreq = 2'b01;
    for (int i = 0; i < 10; i++) begin
      exp_g = ((i % 5) == 4) ? 2'b10 : 2'b01;
      tick();
      checks++;
      if (b_grant !== exp_g) begin
        errors++;
        $display("FAIL fixed_grant[%0d]: grant=%b need %b", i, b_grant, exp_g);
      end
      s_rdone = 1'b1;
      tick();
      s_rdone = 1'b0;
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_write_passthrough();
    do_reset();
    m1_wmask = 4'b0011;
    m1_wdata = 32'hA5A51234;
    m1_waddr = 30'h2A;
    tick();
    checks++;
    if (a_grant !== 2'b10 || a_s_wmask !== 4'b0011 || a_s_wdata !== 32'hA5A51234 || a_s_waddr !== 30'h2A) begin
      errors++;
      $display("FAIL write_forward: grant=%b wmask=%b wdata=%h waddr=%h need 10/0011/a5a51234/2a",
               a_grant, a_s_wmask, a_s_wdata, a_s_waddr);
    end
    s_wdone = 1'b1;
    #1;
    checks++;
    if (a_m1_wdone !== 1'b1 || a_m0_wdone !== 1'b0) begin
      errors++;
      $display("FAIL write_done: m1_wdone=%b m0_wdone=%b need 1/0", a_m1_wdone, a_m0_wdone);
    end
    tick();
    s_wdone = 1'b0;
    checks++;
    if (a_s_wmask !== 4'b0000 || a_state !== S_DRAIN || a_m1_wdone !== 1'b0) begin
      errors++;
      $display("FAIL write_drain: wmask=%b state=%0d m1_wdone=%b need 0000/2/0",
               a_s_wmask, a_state, a_m1_wdone);
    end
    m1_wmask = '0;
    tick();
    checks++;
    if (a_state !== S_IDLE) begin
      errors++;
      $display("FAIL write_idle: state=%0d need 0", a_state);
    end
  endtask

  task automatic test_ena_hold();
    do_reset();
    m0_rreq = 2'b01;
    m0_raddr = 30'h55;
    tick();
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (a_state !== S_BUSY || a_grant !== 2'b01 || a_s_rreq !== 2'b01) begin
        errors++;
        $display("FAIL ena_hold[%0d]: state=%0d grant=%b rreq=%b need 1/01/01",
                 i, a_state, a_grant, a_s_rreq);
      end
    end
    ena = 1'b1;
    s_rdone = 1'b1;
    #1;
    checks++;
    if (a_m0_rdone !== 1'b1) begin
      errors++;
      $display("FAIL ena_done: m0_rdone=%b need 1", a_m0_rdone);
    end
    tick();
    s_rdone = 1'b0;
    m0_rreq = 2'b00;
    checks++;
    if (a_state !== S_DRAIN) begin
      errors++;
      $display("FAIL ena_drain: state=%0d need 2", a_state);
    end
    tick();
    checks++;
    if (a_state !== S_IDLE || a_grant !== 2'b00) begin
      errors++;
      $display("FAIL ena_idle: state=%0d grant=%b need 0/00", a_state, a_grant);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_rr_tie();
    test_fixed_prio();
    test_write_passthrough();
    test_ena_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
